// File: rtl/mem_bridge.sv
// mem_bridge
// Stateful bridge from the CPU byte-addressed memory port to a 32-bit
// word-addressed memory with per-byte write enables. An access that crosses
// a word boundary is either split into two word transactions and reassembled
// (ALLOW_UNALIGNED=1) or completed at once with a misalignment flag
// (ALLOW_UNALIGNED=0).
//
// Ports
//   clk          single clock, rising edge
//   reset        asynchronous, active-high
//   mem_init     one-cycle CPU request pulse, sampled only when idle
//   mem_read_op  [1:0] load size (0 none, 1 byte, 2 half, 3 word), [2] unsigned
//   mem_write_op store size (0 none, 1 byte, 2 half, 3 word)
//   addr         CPU byte address
//   wdata        CPU store data, right-aligned
//   rdata        load result, right-aligned and extended, held between loads
//   mem_ready    one-cycle completion pulse to the CPU
//   misaligned   pulses with mem_ready for a refused crossing access
//   bus_addr     memory word address, stable until bus_ready
//   bus_re       one-cycle read request pulse
//   bus_we       one-cycle per-byte write request pulse
//   bus_wdata    lane-aligned store data, stable until bus_ready
//   bus_rdata    memory read data, valid with bus_ready
//   bus_ready    one-cycle completion pulse from memory
module mem_bridge #(
  parameter int ALLOW_UNALIGNED = 1,
  parameter int WORD_ADDR_WIDTH = 30
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       mem_init,
  input  logic [2:0]                 mem_read_op,
  input  logic [1:0]                 mem_write_op,
  input  logic [31:0]                addr,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata,
  output logic                       mem_ready,
  output logic                       misaligned,
  output logic [WORD_ADDR_WIDTH-1:0] bus_addr,
  output logic                       bus_re,
  output logic [3:0]                 bus_we,
  output logic [31:0]                bus_wdata,
  input  logic [31:0]                bus_rdata,
  input  logic                       bus_ready
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FIRST  = 2'd1,
    ST_SECOND = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                     state_q;
  logic [31:0]                rdata_q;
  logic                       mem_ready_q;
  logic                       misaligned_q;
  logic [WORD_ADDR_WIDTH-1:0] bus_addr_q;
  logic                       bus_re_q;
  logic [3:0]                 bus_we_q;
  logic [31:0]                bus_wdata_q;

  // Request attributes latched at acceptance
  logic [1:0]  sz_q;
  logic [1:0]  off_q;
  logic        is_read_q;
  logic        unsigned_q;
  logic        cross_q;
  logic [31:0] wdata_q;
  logic [31:0] data0_q;

  // Decode of the incoming request
  logic        req_is_read;
  logic [1:0]  req_sz;
  logic [1:0]  req_off;
  logic        req_cross;
  logic [3:0]  first_mask_d;
  logic [31:0] first_data_d;
  logic [3:0]  second_mask_d;
  logic [31:0] second_data_d;

  // Load assembly
  logic [31:0] lo_word;
  logic [31:0] hi_word;
  logic [31:0] raw_d;
  logic [31:0] rdata_d;

  function automatic logic [3:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd1:    size_mask = 4'b0001;
      2'd2:    size_mask = 4'b0011;
      2'd3:    size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  endfunction

  // A nonzero load size wins; the store op is then ignored
  assign req_is_read = |mem_read_op[1:0];
  assign req_sz      = req_is_read ? mem_read_op[1:0] : mem_write_op;
  assign req_off     = addr[1:0];
  assign req_cross   = ((req_sz == 2'd2) && (req_off == 2'd3)) ||
                       ((req_sz == 2'd3) && (req_off != 2'd0));

  // First word takes the low part of the store shifted up into lanes o..3;
  // the second word takes what spilled past lane 3
  assign first_mask_d  = size_mask(req_sz) << req_off;
  assign first_data_d  = wdata << {req_off, 3'b000};
  assign second_mask_d = size_mask(sz_q) >> (3'd4 - {1'b0, off_q});
  assign second_data_d = wdata_q >> (6'd32 - {1'b0, off_q, 3'b000});

  // In FIRST the incoming word is the low word; in SECOND the stored first
  // word is the low word and the incoming one supplies the high bytes
  assign lo_word = (state_q == ST_FIRST) ? bus_rdata : data0_q;
  assign hi_word = (state_q == ST_FIRST) ? 32'd0 : bus_rdata;
  assign raw_d   = 32'({hi_word, lo_word} >> {off_q, 3'b000});

  always_comb begin
    rdata_d = raw_d;
    case (sz_q)
      2'd1: rdata_d = unsigned_q ? {24'd0, raw_d[7:0]}
                                 : {{24{raw_d[7]}}, raw_d[7:0]};
      2'd2: rdata_d = unsigned_q ? {16'd0, raw_d[15:0]}
                                 : {{16{raw_d[15]}}, raw_d[15:0]};
      default: rdata_d = raw_d;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      rdata_q      <= 32'd0;
      mem_ready_q  <= 1'b0;
      misaligned_q <= 1'b0;
      bus_addr_q   <= '0;
      bus_re_q     <= 1'b0;
      bus_we_q     <= 4'd0;
      bus_wdata_q  <= 32'd0;
      sz_q         <= 2'd0;
      off_q        <= 2'd0;
      is_read_q    <= 1'b0;
      unsigned_q   <= 1'b0;
      cross_q      <= 1'b0;
      wdata_q      <= 32'd0;
      data0_q      <= 32'd0;
    end else begin
      // Request and completion strobes are single-cycle pulses
      bus_re_q     <= 1'b0;
      bus_we_q     <= 4'd0;
      mem_ready_q  <= 1'b0;
      misaligned_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (mem_init) begin
            sz_q       <= req_sz;
            off_q      <= req_off;
            is_read_q  <= req_is_read;
            unsigned_q <= mem_read_op[2];
            cross_q    <= req_cross;
            wdata_q    <= wdata;
            if (req_sz == 2'd0) begin
              mem_ready_q <= 1'b1;
              state_q     <= ST_DONE;
            end else if (req_cross && (ALLOW_UNALIGNED == 0)) begin
              mem_ready_q  <= 1'b1;
              misaligned_q <= 1'b1;
              rdata_q      <= 32'd0;
              state_q      <= ST_DONE;
            end else begin
              bus_addr_q <= addr[WORD_ADDR_WIDTH+1:2];
              if (req_is_read) begin
                bus_re_q <= 1'b1;
              end else begin
                bus_we_q    <= first_mask_d;
                bus_wdata_q <= first_data_d;
              end
              state_q <= ST_FIRST;
            end
          end
        end

        ST_FIRST: begin
          if (bus_ready) begin
            data0_q <= bus_rdata;
            if (cross_q) begin
              // Word address wraps naturally at the bus width
              bus_addr_q <= bus_addr_q + WORD_ADDR_WIDTH'(1);
              if (is_read_q) begin
                bus_re_q <= 1'b1;
              end else begin
                bus_we_q    <= second_mask_d;
                bus_wdata_q <= second_data_d;
              end
              state_q <= ST_SECOND;
            end else begin
              if (is_read_q) begin
                rdata_q <= rdata_d;
              end
              mem_ready_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end

        ST_SECOND: begin
          if (bus_ready) begin
            if (is_read_q) begin
              rdata_q <= rdata_d;
            end
            mem_ready_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rdata      = rdata_q;
  assign mem_ready  = mem_ready_q;
  assign misaligned = misaligned_q;
  assign bus_addr   = bus_addr_q;
  assign bus_re     = bus_re_q;
  assign bus_we     = bus_we_q;
  assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_mem_bridge.sv
module tb_mem_bridge;

  logic        clk;
  logic        reset;
  logic        mem_init;
  logic        na_init;
  logic [2:0]  mem_read_op;
  logic [1:0]  mem_write_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] bus_rdata;
  logic        bus_ready;

  logic [31:0] rdata;
  logic        mem_ready;
  logic        misaligned;
  logic [29:0] bus_addr;
  logic        bus_re;
  logic [3:0]  bus_we;
  logic [31:0] bus_wdata;

  logic [31:0] na_rdata;
  logic        na_mem_ready;
  logic        na_misaligned;
  logic [29:0] na_bus_addr;
  logic        na_bus_re;
  logic [3:0]  na_bus_we;
  logic [31:0] na_bus_wdata;

  int n_cmp;
  int n_bad;

  mem_bridge #(.ALLOW_UNALIGNED(1), .WORD_ADDR_WIDTH(30)) dut (
    .clk(clk), .reset(reset), .mem_init(mem_init),
    .mem_read_op(mem_read_op), .mem_write_op(mem_write_op),
    .addr(addr), .wdata(wdata), .rdata(rdata), .mem_ready(mem_ready),
    .misaligned(misaligned), .bus_addr(bus_addr), .bus_re(bus_re),
    .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready)
  );

  mem_bridge #(.ALLOW_UNALIGNED(0), .WORD_ADDR_WIDTH(30)) dut_na (
    .clk(clk), .reset(reset), .mem_init(na_init),
    .mem_read_op(mem_read_op), .mem_write_op(mem_write_op),
    .addr(addr), .wdata(wdata), .rdata(na_rdata), .mem_ready(na_mem_ready),
    .misaligned(na_misaligned), .bus_addr(na_bus_addr), .bus_re(na_bus_re),
    .bus_we(na_bus_we), .bus_wdata(na_bus_wdata), .bus_rdata(bus_rdata),
    .bus_ready(bus_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: run did not finish, got no summary, want summary");
    $fatal(1);
  end

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a one-cycle request; returns in cycle 1
  task automatic issue(input logic [2:0] rop, input logic [1:0] wop,
                       input logic [31:0] a, input logic [31:0] wd);
    mem_read_op  = rop;
    mem_write_op = wop;
    addr         = a;
    wdata        = wd;
    mem_init     = 1'b1;
    tick();
    mem_init     = 1'b0;
  endtask

  // One-cycle bus_ready with data; returns in the following cycle
  task automatic ready_pulse(input logic [31:0] d);
    bus_rdata = d;
    bus_ready = 1'b1;
    tick();
    bus_ready = 1'b0;
    bus_rdata = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want %h", rdata, 32'h0); end
    n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL reset_mem_ready: got %b want 0", mem_ready); end
    n_cmp++; if (misaligned !== 1'b0) begin n_bad++; $display("FAIL reset_misaligned: got %b want 0", misaligned); end
    n_cmp++; if (bus_re !== 1'b0) begin n_bad++; $display("FAIL reset_bus_re: got %b want 0", bus_re); end
    n_cmp++; if (bus_we !== 4'b0000) begin n_bad++; $display("FAIL reset_bus_we: got %b want 0000", bus_we); end
    n_cmp++; if (bus_addr !== 30'h0) begin n_bad++; $display("FAIL reset_bus_addr: got %h want 0", bus_addr); end
    n_cmp++; if (bus_wdata !== 32'h0) begin n_bad++; $display("FAIL reset_bus_wdata: got %h want 0", bus_wdata); end
    reset = 1'b0;
    tick();
    $display("reset: outputs checked");
  endtask

  task automatic test_aligned_lw();
    issue(3'b011, 2'd0, 32'h0000_0100, 32'h0);
    n_cmp++; if (bus_re !== 1'b1) begin n_bad++; $display("FAIL lw_re_c1: got %b want 1", bus_re); end
    n_cmp++; if (bus_addr !== 30'h40) begin n_bad++; $display("FAIL lw_addr: got %h want %h", bus_addr, 30'h40); end
    n_cmp++; if (bus_we !== 4'b0000) begin n_bad++; $display("FAIL lw_we: got %b want 0000", bus_we); end
    ready_pulse(32'hDEAD_BEEF);
    n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL lw_ready_c3: got %b want 1", mem_ready); end
    n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_rdata: got %h want %h", rdata, 32'hDEAD_BEEF); end
    tick();
    n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL lw_ready_pulse: got %b want 0", mem_ready); end
    n_cmp++; if (rdata !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL lw_rdata_held: got %h want %h", rdata, 32'hDEAD_BEEF); end
    $display("aligned LW 0x100 -> %h", rdata);
  endtask

  task automatic test_lb_lbu();
    issue(3'b001, 2'd0, 32'h0000_0103, 32'h0);
    n_cmp++; if (bus_addr !== 30'h40) begin n_bad++; $display("FAIL lb_addr: got %h want %h", bus_addr, 30'h40); end
    ready_pulse(32'h8011_2233);
    n_cmp++; if (rdata !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL lb_rdata: got %h want %h", rdata, 32'hFFFF_FF80); end
    $display("LB 0x103 -> %h", rdata);
    tick();
    issue(3'b101, 2'd0, 32'h0000_0103, 32'h0);
    ready_pulse(32'h8011_2233);
    n_cmp++; if (rdata !== 32'h0000_0080) begin n_bad++; $display("FAIL lbu_rdata: got %h want %h", rdata, 32'h0000_0080); end
    $display("LBU 0x103 -> %h", rdata);
    tick();
  endtask

  task automatic test_unaligned_sw();
    issue(3'b000, 2'd3, 32'h0000_000E, 32'hAABB_CCDD);
    n_cmp++; if (bus_we !== 4'b1100) begin n_bad++; $display("FAIL sw1_we: got %b want 1100", bus_we); end
    n_cmp++; if (bus_wdata !== 32'hCCDD_0000) begin n_bad++; $display("FAIL sw1_data: got %h want %h", bus_wdata, 32'hCCDD_0000); end
    n_cmp++; if (bus_addr !== 30'h3) begin n_bad++; $display("FAIL sw1_addr: got %h want 3", bus_addr); end
    tick();
    n_cmp++; if (bus_we !== 4'b0000) begin n_bad++; $display("FAIL sw1_we_pulse: got %b want 0000", bus_we); end
    n_cmp++; if (bus_wdata !== 32'hCCDD_0000) begin n_bad++; $display("FAIL sw1_data_hold: got %h want %h", bus_wdata, 32'hCCDD_0000); end
    ready_pulse(32'h0);
    n_cmp++; if (bus_we !== 4'b0011) begin n_bad++; $display("FAIL sw2_we: got %b want 0011", bus_we); end
    n_cmp++; if (bus_wdata !== 32'h0000_AABB) begin n_bad++; $display("FAIL sw2_data: got %h want %h", bus_wdata, 32'h0000_AABB); end
    n_cmp++; if (bus_addr !== 30'h4) begin n_bad++; $display("FAIL sw2_addr: got %h want 4", bus_addr); end
    n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL sw_early_ready: got %b want 0", mem_ready); end
    ready_pulse(32'h0);
    n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL sw_ready: got %b want 1", mem_ready); end
    $display("unaligned SW 0x0E done");
    tick();
  endtask

  task automatic test_unaligned_lh();
    issue(3'b010, 2'd0, 32'h0000_0007, 32'h0);
    n_cmp++; if (bus_addr !== 30'h1) begin n_bad++; $display("FAIL lh1_addr: got %h want 1", bus_addr); end
    ready_pulse(32'h1133_4455);
    n_cmp++; if (bus_re !== 1'b1) begin n_bad++; $display("FAIL lh2_re: got %b want 1", bus_re); end
    n_cmp++; if (bus_addr !== 30'h2) begin n_bad++; $display("FAIL lh2_addr: got %h want 2", bus_addr); end
    ready_pulse(32'h6677_8822);
    n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL lh_ready: got %b want 1", mem_ready); end
    n_cmp++; if (rdata !== 32'h0000_2211) begin n_bad++; $display("FAIL lh_rdata: got %h want %h", rdata, 32'h0000_2211); end
    $display("unaligned LH 0x07 -> %h", rdata);
    tick();
    // Wrapping case, negative halfword 0xFF80
    issue(3'b010, 2'd0, 32'hFFFF_FFFF, 32'h0);
    n_cmp++; if (bus_addr !== 30'h3FFF_FFFF) begin n_bad++; $display("FAIL wrap1_addr: got %h want %h", bus_addr, 30'h3FFF_FFFF); end
    ready_pulse(32'h8000_0000);
    n_cmp++; if (bus_addr !== 30'h0) begin n_bad++; $display("FAIL wrap2_addr: got %h want 0", bus_addr); end
    ready_pulse(32'h0000_00FF);
    n_cmp++; if (rdata !== 32'hFFFF_FF80) begin n_bad++; $display("FAIL wrap_rdata: got %h want %h", rdata, 32'hFFFF_FF80); end
    $display("wrap LH 0xFFFFFFFF -> %h", rdata);
    tick();
  endtask

  task automatic test_zero_op();
    issue(3'b100, 2'd0, 32'h0000_0020, 32'h0);
    n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL zero_ready: got %b want 1", mem_ready); end
    n_cmp++; if (bus_re !== 1'b0 || bus_we !== 4'b0000) begin n_bad++; $display("FAIL zero_bus: got re=%b we=%b want 0/0000", bus_re, bus_we); end
    n_cmp++; if (misaligned !== 1'b0) begin n_bad++; $display("FAIL zero_misaligned: got %b want 0", misaligned); end
    $display("zero-op completed");
    tick();
  endtask

  task automatic test_misaligned_flag();
    mem_read_op  = 3'b011;
    mem_write_op = 2'd0;
    addr         = 32'h0000_0002;
    na_init      = 1'b1;
    tick();
    na_init      = 1'b0;
    n_cmp++; if (na_mem_ready !== 1'b1) begin n_bad++; $display("FAIL na_ready: got %b want 1", na_mem_ready); end
    n_cmp++; if (na_misaligned !== 1'b1) begin n_bad++; $display("FAIL na_misaligned: got %b want 1", na_misaligned); end
    n_cmp++; if (na_bus_re !== 1'b0) begin n_bad++; $display("FAIL na_bus_re: got %b want 0", na_bus_re); end
    n_cmp++; if (na_rdata !== 32'h0) begin n_bad++; $display("FAIL na_rdata: got %h want 0", na_rdata); end
    tick();
    n_cmp++; if (na_misaligned !== 1'b0) begin n_bad++; $display("FAIL na_misaligned_pulse: got %b want 0", na_misaligned); end
    $display("misaligned LW 0x02 flagged");
  endtask

  task automatic test_reset_mid();
    issue(3'b011, 2'd0, 32'h0000_0001, 32'h0);
    ready_pulse(32'h1234_5678);
    n_cmp++; if (bus_re !== 1'b1) begin n_bad++; $display("FAIL mid_second_re: got %b want 1", bus_re); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus_re !== 1'b0 || bus_addr !== 30'h0 || bus_wdata !== 32'h0 || bus_we !== 4'b0000)
      begin n_bad++; $display("FAIL mid_bus_clear: got re=%b addr=%h wd=%h we=%b want zeros", bus_re, bus_addr, bus_wdata, bus_we); end
    n_cmp++; if (rdata !== 32'h0 || mem_ready !== 1'b0 || misaligned !== 1'b0)
      begin n_bad++; $display("FAIL mid_cpu_clear: got rdata=%h rdy=%b mis=%b want zeros", rdata, mem_ready, misaligned); end
    tick();
    reset     = 1'b0;
    bus_ready = 1'b1;
    bus_rdata = 32'h9ABC_DEF0;
    tick();
    bus_ready = 1'b0;
    n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL mid_stale_ready: got %b want 0", mem_ready); end
    tick();
    n_cmp++; if (mem_ready !== 1'b0) begin n_bad++; $display("FAIL mid_stale_ready2: got %b want 0", mem_ready); end
    $display("reset in SECOND aborted");
    issue(3'b011, 2'd0, 32'h0000_0010, 32'h0);
    n_cmp++; if (bus_addr !== 30'h4) begin n_bad++; $display("FAIL post_addr: got %h want 4", bus_addr); end
    ready_pulse(32'h0BAD_F00D);
    n_cmp++; if (mem_ready !== 1'b1 || rdata !== 32'h0BAD_F00D)
      begin n_bad++; $display("FAIL post_lw: got rdy=%b rdata=%h want 1/%h", mem_ready, rdata, 32'h0BAD_F00D); end
    $display("LW after reset -> %h", rdata);
  endtask

  task automatic test_back_to_back();
    tick();
    issue(3'b011, 2'd0, 32'h0000_0200, 32'h0);
    // mem_init while busy must not disturb the pending access
    mem_read_op = 3'b000; mem_write_op = 2'd3; addr = 32'h0000_0300; mem_init = 1'b1;
    tick();
    mem_init = 1'b0;
    n_cmp++; if (bus_addr !== 30'h80 || bus_we !== 4'b0000) begin n_bad++; $display("FAIL busy_init: got addr=%h we=%b want 80/0000", bus_addr, bus_we); end
    ready_pulse(32'hCAFE_0001);
    n_cmp++; if (mem_ready !== 1'b1 || rdata !== 32'hCAFE_0001) begin n_bad++; $display("FAIL b2b_lw: got rdy=%b rdata=%h want 1/%h", mem_ready, rdata, 32'hCAFE_0001); end
    tick();
    issue(3'b000, 2'd1, 32'h0000_0205, 32'h0000_00AB);
    n_cmp++; if (bus_we !== 4'b0010) begin n_bad++; $display("FAIL b2b_sb_we: got %b want 0010", bus_we); end
    n_cmp++; if (bus_wdata !== 32'h0000_AB00) begin n_bad++; $display("FAIL b2b_sb_data: got %h want %h", bus_wdata, 32'h0000_AB00); end
    n_cmp++; if (bus_addr !== 30'h81) begin n_bad++; $display("FAIL b2b_sb_addr: got %h want 81", bus_addr); end
    ready_pulse(32'h0);
    n_cmp++; if (mem_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_sb_ready: got %b want 1", mem_ready); end
    $display("back-to-back LW + SB done");
    tick();
  endtask

  initial begin
    n_cmp        = 0;
    n_bad        = 0;
    reset        = 1'b1;
    mem_init     = 1'b0;
    na_init      = 1'b0;
    mem_read_op  = 3'b000;
    mem_write_op = 2'd0;
    addr         = 32'h0;
    wdata        = 32'h0;
    bus_rdata    = 32'h0;
    bus_ready    = 1'b0;
    #1;
    test_reset();
    test_aligned_lw();
    test_lb_lbu();
    test_unaligned_sw();
    test_unaligned_lh();
    test_zero_op();
    test_misaligned_flag();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
